// File: rtl/gcd_stein.sv
// rtl/gcd_stein.sv - binary GCD (Stein) engine with valid/ready on operands and result
module gcd_stein #(
  parameter int XLEN  = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  gcd_o,
  output logic [CNT_W-1:0] cycles_o
);

  localparam int KW = $clog2(XLEN + 1);
  localparam logic [KW-1:0]    K_ONE   = KW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic [CNT_W-1:0] cnt_inc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      res_q   <= res_d;
    end
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d   = a_i;
          b_d   = b_i;
          k_d   = '0;
          cnt_d = '0;
          // A zero operand short-circuits straight to the result.
          if (a_i == '0) begin
            res_d   = b_i;
            cyc_d   = '0;
            state_d = DONE;
          end else if (b_i == '0) begin
            res_d   = a_i;
            cyc_d   = '0;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_inc;
        if (a_q == b_q) begin
          res_d   = a_q << k_q;
          cyc_d   = cnt_inc;
          state_d = DONE;
        end else if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + K_ONE;
        end else if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q > b_q) begin
          a_d = (a_q - b_q) >> 1;
        end else begin
          b_d = (b_q - a_q) >> 1;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign gcd_o       = res_q;
  assign cycles_o    = cyc_q;

endmodule
